// File: rtl/m3_phase_pwm_gen.sv
// m3_phase_pwm_gen
//   Three-phase sine-weighted, centre-offset PWM generator with per-phase
//   dead-time insertion. Sits downstream of the power/speed calculator.
//
// Ports
//   clkI        system clock (1 MHz)
//   nRstI       asynchronous active-low reset
//   enableI     1 = run, 0 = idle (all gates off)
//   forceStopI  1 = all gates off from the next cycle, overrides everything
//   stepI       electrical angle index 0..11, 12..15 = idle
//   powerI      amplitude 0..1023
//   invRotateI  1 = reverse phase sequence (V and W swapped)
//   uHo..wLo    half-bridge gate drives, active-high
//   pwmSyncO    one-cycle pulse while the carrier counter is on its last count
module m3_phase_pwm_gen #(
  parameter int PWM_PERIOD = 40,
  parameter int DEAD_CLK   = 2
) (
  input  logic       clkI,
  input  logic       nRstI,
  input  logic       enableI,
  input  logic       forceStopI,
  input  logic [3:0] stepI,
  input  logic [9:0] powerI,
  input  logic       invRotateI,
  output logic       uHo,
  output logic       uLo,
  output logic       vHo,
  output logic       vLo,
  output logic       wHo,
  output logic       wLo,
  output logic       pwmSyncO
);

  localparam logic [7:0] CNT_LAST = 8'(PWM_PERIOD - 1);
  localparam logic [7:0] CNT_PRE  = 8'(PWM_PERIOD - 2);
  localparam logic [7:0] CMP_MID  = 8'((PWM_PERIOD * 128) >> 8);
  localparam logic [2:0] DEAD     = 3'(DEAD_CLK);

  function automatic logic signed [7:0] sineOf(input logic [3:0] k);
    case (k)
      4'd1:    return  8'sd64;
      4'd2:    return  8'sd110;
      4'd3:    return  8'sd127;
      4'd4:    return  8'sd110;
      4'd5:    return  8'sd64;
      4'd7:    return -8'sd64;
      4'd8:    return -8'sd110;
      4'd9:    return -8'sd127;
      4'd10:   return -8'sd110;
      4'd11:   return -8'sd64;
      default: return  8'sd0;
    endcase
  endfunction

  // Compare value for one phase: floor-scaled sine around mid-scale, then
  // mapped onto the carrier. m stays within 1..254, so cmp < PWM_PERIOD.
  function automatic logic [7:0] dutyOf(input logic [3:0] k, input logic [9:0] pwr);
    logic signed [18:0] s19;
    logic signed [18:0] p19;
    logic signed [18:0] prod;
    logic signed [18:0] mFull;
    logic        [7:0]  mByte;
    logic        [15:0] scaled;
    s19    = 19'(sineOf(k));
    p19    = {9'd0, pwr};
    prod   = s19 * p19;
    mFull  = (prod >>> 10) + 19'sd128;
    mByte  = 8'(mFull);
    scaled = 16'(mByte) * 16'(PWM_PERIOD);
    return 8'(scaled >> 8);
  endfunction

  logic       idle;
  logic       wasIdle;
  logic       load;
  logic [7:0] cnt;
  logic       syncQ;
  logic [3:0] idxPlus8;
  logic [3:0] idxPlus4;
  logic [7:0] cmpNew [3];
  logic [7:0] cmpReg [3];
  logic [7:0] cmpUse [3];
  logic       raw    [3];
  logic       rawPrev[3];
  logic       change [3];
  logic [2:0] dead   [3];
  logic [2:0] deadNext[3];
  logic       gateH  [3];
  logic       gateL  [3];

  assign idle = !enableI || forceStopI || (stepI > 4'd11);
  assign load = !idle && (wasIdle || cnt == CNT_LAST);

  // Stage p0: phase indices, new compares and raw comparator state
  always_comb begin
    idxPlus8 = (stepI >= 4'd4) ? stepI - 4'd4 : stepI + 4'd8;
    idxPlus4 = (stepI >= 4'd8) ? stepI - 4'd8 : stepI + 4'd4;
    cmpNew[0] = dutyOf(stepI, powerI);
    cmpNew[1] = dutyOf(invRotateI ? idxPlus4 : idxPlus8, powerI);
    cmpNew[2] = dutyOf(invRotateI ? idxPlus8 : idxPlus4, powerI);
    for (int i = 0; i < 3; i++) begin
      // The first run cycle after idle must already see the fresh compare at cnt=0.
      cmpUse[i] = wasIdle ? cmpNew[i] : cmpReg[i];
      raw[i]    = cnt < cmpUse[i];
      // Coming out of idle counts as an edge so the full dead-time is applied.
      change[i] = wasIdle || (raw[i] != rawPrev[i]);
      if (change[i]) begin
        deadNext[i] = DEAD;
      end else if (dead[i] != 3'd0) begin
        deadNext[i] = dead[i] - 3'd1;
      end else begin
        deadNext[i] = 3'd0;
      end
    end
  end

  // Stage p1: carrier, shadow compares, dead-time and registered gates
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      cnt     <= 8'd0;
      syncQ   <= 1'b0;
      wasIdle <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        cmpReg[i]  <= CMP_MID;
        rawPrev[i] <= 1'b0;
        dead[i]    <= DEAD;
        gateH[i]   <= 1'b0;
        gateL[i]   <= 1'b0;
      end
    end else begin
      wasIdle <= idle;
      if (idle) begin
        cnt   <= 8'd0;
        syncQ <= 1'b0;
        for (int i = 0; i < 3; i++) begin
          dead[i]  <= DEAD;
          gateH[i] <= 1'b0;
          gateL[i] <= 1'b0;
        end
      end else begin
        cnt   <= (cnt == CNT_LAST) ? 8'd0 : cnt + 8'd1;
        syncQ <= (cnt == CNT_PRE);
        for (int i = 0; i < 3; i++) begin
          if (load) cmpReg[i] <= cmpNew[i];
          rawPrev[i] <= raw[i];
          dead[i]    <= deadNext[i];
          gateH[i]   <= !change[i] && (deadNext[i] == 3'd0) &&  raw[i];
          gateL[i]   <= !change[i] && (deadNext[i] == 3'd0) && !raw[i];
        end
      end
    end
  end

  assign uHo      = gateH[0];
  assign uLo      = gateL[0];
  assign vHo      = gateH[1];
  assign vLo      = gateL[1];
  assign wHo      = gateH[2];
  assign wLo      = gateL[2];
  assign pwmSyncO = syncQ;

endmodule

// File: tb/tb_m3_phase_pwm_gen.sv
// Testbench for m3_phase_pwm_gen: directed carriers checked by a scoreboard
// of per-carrier gate high-times, plus directed start/stop/reset checks and
// a continuous shoot-through / dead-time checker under random stimulus.
module tb_m3_phase_pwm_gen;

  localparam int P = 40;
  localparam int D = 2;

  logic       clkI = 1'b0;
  logic       nRstI = 1'b0;
  logic       enableI = 1'b0;
  logic       forceStopI = 1'b0;
  logic [3:0] stepI = 4'd0;
  logic [9:0] powerI = 10'd0;
  logic       invRotateI = 1'b0;
  logic       uHo, uLo, vHo, vLo, wHo, wLo, pwmSyncO;

  always #5 clkI = ~clkI;

  m3_phase_pwm_gen #(.PWM_PERIOD(P), .DEAD_CLK(D)) dut (
    .clkI(clkI), .nRstI(nRstI), .enableI(enableI), .forceStopI(forceStopI),
    .stepI(stepI), .powerI(powerI), .invRotateI(invRotateI),
    .uHo(uHo), .uLo(uLo), .vHo(vHo), .vLo(vLo), .wHo(wHo), .wLo(wLo),
    .pwmSyncO(pwmSyncO)
  );

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    bit chk;
    int uh, ul, vh, vl, wh, wl;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: integrates gate high-time over each carrier, the
  // window closing on the pwmSyncO cycle.
  int cnts[6];
  int period = 0;
  always @(negedge clkI) begin
    exp_t e;
    if (!nRstI) begin
      for (int i = 0; i < 6; i++) cnts[i] = 0;
      period = 0;
    end else begin
      cnts[0] += int'(uHo); cnts[1] += int'(uLo);
      cnts[2] += int'(vHo); cnts[3] += int'(vLo);
      cnts[4] += int'(wHo); cnts[5] += int'(wLo);
      period++;
      if (pwmSyncO) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          if (e.chk) begin
            check("period", period, P);
            check("uH_time", cnts[0], e.uh);
            check("uL_time", cnts[1], e.ul);
            check("vH_time", cnts[2], e.vh);
            check("vL_time", cnts[3], e.vl);
            check("wH_time", cnts[4], e.wh);
            check("wL_time", cnts[5], e.wl);
          end
        end
        for (int i = 0; i < 6; i++) cnts[i] = 0;
        period = 0;
      end
    end
  end

  // Shoot-through and dead-time checker, always running.
  int zr[3];
  int lastOn[3];
  always @(negedge clkI) begin
    logic h[3];
    logic l[3];
    h[0] = uHo; l[0] = uLo; h[1] = vHo; l[1] = vLo; h[2] = wHo; l[2] = wLo;
    for (int i = 0; i < 3; i++) begin
      check("no_overlap", h[i] & l[i], 1'b0);
      if (!nRstI) begin
        lastOn[i] = 0; zr[i] = 0;
      end else if (h[i]) begin
        if (lastOn[i] == 2) check("deadtime_LH", zr[i] >= D, 1'b1);
        lastOn[i] = 1; zr[i] = 0;
      end else if (l[i]) begin
        if (lastOn[i] == 1) check("deadtime_HL", zr[i] >= D, 1'b1);
        lastOn[i] = 2; zr[i] = 0;
      end else begin
        zr[i]++;
      end
    end
  end

  task automatic waitSync(input int n);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < 200 * n + 100) begin
      @(negedge clkI);
      cyc++;
      if (pwmSyncO) seen++;
    end
    check("sync_wait", seen, n);
  endtask

  // Called on the negedge of a sync cycle: new inputs are loaded at the wrap.
  // The first carrier is left unchecked because its cnt=0 low-gate sample
  // still belongs to the previous setting.
  task automatic runVec(input logic [3:0] s, input logic [9:0] p, input logic inv,
                        input int uh, input int ul, input int vh, input int vl,
                        input int wh, input int wl, input int n);
    #1;
    stepI = s; powerI = p; invRotateI = inv;
    sb.push_back('{1'b0, 0, 0, 0, 0, 0, 0});
    for (int i = 1; i < n; i++) sb.push_back('{1'b1, uh, ul, vh, vl, wh, wl});
    waitSync(n);
  endtask

  // Assumes inputs were just released from idle (cycle with cnt=0).
  task automatic checkRestart(input string tag);
    int k;
    @(negedge clkI); check({tag, "_gap1"}, {uHo, uLo}, 2'b00);
    @(negedge clkI); check({tag, "_gap2"}, {uHo, uLo}, 2'b00);
    @(negedge clkI); check({tag, "_uH_on"}, uHo, 1'b1);
    k = 3;
    while (!pwmSyncO && k < 200) begin
      @(negedge clkI);
      k++;
    end
    check({tag, "_first_sync"}, k, P - 1);
  endtask

  initial begin
    nRstI = 1'b0;
    repeat (3) @(negedge clkI);
    check("reset_outputs", {uHo, uLo, vHo, vLo, wHo, wLo, pwmSyncO}, 7'd0);
    #1 nRstI = 1'b1;
    repeat (2) @(negedge clkI);
    check("idle_outputs", {uHo, uLo, vHo, vLo, wHo, wLo, pwmSyncO}, 7'd0);

    // Start from idle: step 3, power 102 (cmp U=21, V=18, W=18)
    #1; enableI = 1'b1; stepI = 4'd3; powerI = 10'd102;
    checkRestart("start");
    runVec(4'd3, 10'd102, 1'b0, 19, 17, 16, 20, 16, 20, 3);

    // Mid-carrier change at cnt=10 must not disturb the running carrier.
    #1 sb.push_back('{1'b1, 19, 17, 16, 20, 16, 20});
    repeat (11) @(negedge clkI);
    #1; stepI = 4'd4; powerI = 10'd512;
    sb.push_back('{1'b0, 0, 0, 0, 0, 0, 0});
    sb.push_back('{1'b1, 26, 10, 18, 18, 9, 27});
    waitSync(3);

    runVec(4'd5, 10'd0,    1'b0, 18, 18, 18, 18, 18, 18, 3);
    runVec(4'd3, 10'd1023, 1'b0, 37,  0,  8, 28,  8, 28, 3);
    runVec(4'd9, 10'd1023, 1'b0,  0, 40, 27,  9, 27,  9, 3);
    runVec(4'd0, 10'd1023, 1'b0, 18, 18,  0, 36, 35,  1, 3);
    runVec(4'd0, 10'd1023, 1'b1, 18, 18, 35,  1,  0, 36, 3);
    runVec(4'd3, 10'd102,  1'b0, 19, 17, 16, 20, 16, 20, 2);

    // forceStopI at cnt=15 while uHo is high
    repeat (16) @(negedge clkI);
    check("pre_stop_uH", uHo, 1'b1);
    #1 forceStopI = 1'b1;
    @(negedge clkI);
    check("stop_gates", {uHo, uLo, vHo, vLo, wHo, wLo, pwmSyncO}, 7'd0);
    repeat (3) @(negedge clkI);
    check("stop_hold", {uHo, uLo, vHo, vLo, wHo, wLo, pwmSyncO}, 7'd0);
    #1 forceStopI = 1'b0;
    checkRestart("force_release");

    // stepI=0xF behaves as idle
    repeat (16) @(negedge clkI);
    check("pre_idle_uH", uHo, 1'b1);
    #1 stepI = 4'hF;
    @(negedge clkI);
    check("idle_step_gates", {uHo, uLo, vHo, vLo, wHo, wLo, pwmSyncO}, 7'd0);
    repeat (3) @(negedge clkI);
    #1 stepI = 4'd3;
    checkRestart("step_release");

    // Asynchronous reset mid-carrier
    repeat (5) @(negedge clkI);
    check("pre_reset_uH", uHo, 1'b1);
    #1 nRstI = 1'b0;
    #1 check("async_reset", {uHo, uLo, vHo, vLo, wHo, wLo, pwmSyncO}, 7'd0);
    repeat (2) @(negedge clkI);
    #1 nRstI = 1'b1;

    // Random stimulus; the overlap / dead-time checker watches every cycle.
    for (int it = 0; it < 250; it++) begin
      repeat ($urandom_range(5, 80)) @(negedge clkI);
      #1;
      stepI      = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 11));
      powerI     = 10'($urandom);
      invRotateI = 1'($urandom);
      forceStopI = ($urandom_range(0, 15) == 0);
      enableI    = ($urandom_range(0, 15) != 0);
    end
    repeat (100) @(negedge clkI);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
